// File: rtl/muu_repeat_header_splitter.sv
// muu_repeat_header_splitter
//
// Upstream command stage for the data repeater. A single input stream carries
// a header word followed by payload words. Each valid header becomes one
// count/size config handshake, and exactly `size` payload words are then
// forwarded through a 2-entry output skid buffer. A header with count=0 has
// its payload consumed and discarded. A header with size=0 has no payload.
// Both kinds are counted as rejects.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready/tlast
//                              input stream (header, then payload)
//   m_config_count/size/valid/ready
//                              config handshake towards the repeater
//   m_axis_tdata/tvalid/tready payload stream towards the repeater
//   hdr_reject_cnt             saturating count of rejected headers
//   tlast_err                  sticky flag for a tlast/framing disagreement
//   busy                       high outside HDR or while payload is buffered
//
// Handshake rule: a word moves on any interface only in a cycle where both
// valid and ready are high at the rising clock edge. A valid, once raised,
// holds its data stable until it is accepted.
module muu_repeat_header_splitter #(
    parameter int DATA_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [7:0]            m_config_count,
    output logic [7:0]            m_config_size,
    output logic                  m_config_valid,
    input  logic                  m_config_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [15:0]           hdr_reject_cnt,
    output logic                  tlast_err,
    output logic                  busy
);

    localparam logic [1:0] ST_HDR  = 2'd0;
    localparam logic [1:0] ST_CFG  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            cfg_count_q, cfg_count_d;
    logic [7:0]            cfg_size_q, cfg_size_d;
    logic [15:0]           rej_q;
    logic                  tlast_err_q;
    logic                  rej_inc;
    logic                  tlast_bad;

    // Skid buffer: buf0_q is the head presented on m_axis.
    logic [DATA_WIDTH-1:0] buf0_q, buf1_q;
    logic [1:0]            fcnt_q;

    logic                  s_acc;
    logic                  push;
    logic                  pop;
    logic                  last_word;
    logic [7:0]            hdr_count;
    logic [7:0]            hdr_size;

    assign hdr_count = s_axis_tdata[7:0];
    assign hdr_size  = s_axis_tdata[15:8];
    assign last_word = (cnt_q == 8'd1);

    // Ready is forced low while reset is asserted so nothing is taken in the
    // reset cycle itself.
    always_comb begin
        s_axis_tready = 1'b0;
        case (state_q)
            ST_HDR:  s_axis_tready = 1'b1;
            ST_CFG:  s_axis_tready = 1'b0;
            ST_PAY:  s_axis_tready = (fcnt_q != 2'd2);
            ST_DROP: s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
        endcase
        if (rst) s_axis_tready = 1'b0;
    end

    assign s_acc = s_axis_tvalid & s_axis_tready;
    assign push  = s_acc & (state_q == ST_PAY);
    assign pop   = m_axis_tvalid & m_axis_tready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cfg_count_d = cfg_count_q;
        cfg_size_d  = cfg_size_q;
        rej_inc     = 1'b0;
        tlast_bad   = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (s_acc) begin
                    if (hdr_size == 8'd0) begin
                        rej_inc = 1'b1;
                    end else if (hdr_count == 8'd0) begin
                        rej_inc = 1'b1;
                        cnt_d   = hdr_size;
                        state_d = ST_DROP;
                    end else begin
                        cnt_d       = hdr_size;
                        cfg_count_d = hdr_count;
                        cfg_size_d  = hdr_size;
                        state_d     = ST_CFG;
                    end
                end
            end
            ST_CFG: begin
                if (m_config_ready) state_d = ST_PAY;
            end
            ST_PAY, ST_DROP: begin
                if (s_acc) begin
                    if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
                    tlast_bad = (s_axis_tlast != last_word);
                    if (last_word) state_d = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HDR;
            cnt_q       <= 8'd0;
            cfg_count_q <= 8'd0;
            cfg_size_q  <= 8'd0;
            rej_q       <= 16'd0;
            tlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_count_q <= cfg_count_d;
            cfg_size_q  <= cfg_size_d;
            if (rej_inc && (rej_q != 16'hFFFF)) rej_q <= rej_q + 16'd1;
            if (tlast_bad) tlast_err_q <= 1'b1;
        end
    end

    // Two-entry FIFO. A push is only possible when not full, so the
    // simultaneous push/pop cases never overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf0_q <= '0;
            buf1_q <= '0;
            fcnt_q <= 2'd0;
        end else begin
            if (push && pop) begin
                if (fcnt_q == 2'd2) begin
                    buf0_q <= buf1_q;
                    buf1_q <= s_axis_tdata;
                end else begin
                    buf0_q <= s_axis_tdata;
                end
            end else if (pop) begin
                buf0_q <= buf1_q;
                fcnt_q <= fcnt_q - 2'd1;
            end else if (push) begin
                if (fcnt_q == 2'd0) buf0_q <= s_axis_tdata;
                else                buf1_q <= s_axis_tdata;
                fcnt_q <= fcnt_q + 2'd1;
            end
        end
    end

    assign m_config_valid = (state_q == ST_CFG);
    assign m_config_count = cfg_count_q;
    assign m_config_size  = cfg_size_q;
    assign m_axis_tvalid  = (fcnt_q != 2'd0);
    assign m_axis_tdata   = buf0_q;
    assign hdr_reject_cnt = rej_q;
    assign tlast_err      = tlast_err_q;
    assign busy           = (state_q != ST_HDR) || (fcnt_q != 2'd0);

endmodule

// File: tb/tb_muu_repeat_header_splitter.sv
module tb_muu_repeat_header_splitter;

    localparam int DW = 512;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [7:0]    cfg_count;
    logic [7:0]    cfg_size;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [15:0]   rej_cnt;
    logic          tl_err;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];

    muu_repeat_header_splitter #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .s_axis_tlast   (s_tlast),
        .m_config_count (cfg_count),
        .m_config_size  (cfg_size),
        .m_config_valid (cfg_valid),
        .m_config_ready (cfg_ready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .hdr_reject_cnt (rej_cnt),
        .tlast_err      (tl_err),
        .busy           (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Output monitor: a transfer is logged when valid & ready are seen
    // mid-cycle, i.e. it completes on the following rising edge.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) got_q.push_back(m_tdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Drive one word and return #1 after the edge that accepted it.
    task automatic send(input logic [DW-1:0] d, input logic last);
        int n;
        n = 0;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        while (!s_tready && n < 100) begin
            tick();
            n++;
        end
        chk("send_wait_bound", (n < 100), 1);
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        cfg_ready = 1'b1;
        m_tready  = 1'b1;

        // ---- reset state ----
        tick();
        chk("rst_s_tready", s_tready, 0);
        chk("rst_cfg_valid", cfg_valid, 0);
        chk("rst_cfg_count", cfg_count, 0);
        chk("rst_cfg_size", cfg_size, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_rej", rej_cnt, 0);
        chk("rst_tlast_err", tl_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_s_tready", s_tready, 1);

        // ---- T1: count=3 size=4, straight through ----
        send(16'h0403, 1'b0);
        chk("t1_cfg_valid", cfg_valid, 1);
        chk("t1_cfg_count", cfg_count, 3);
        chk("t1_cfg_size", cfg_size, 4);
        chk("t1_s_tready_cfg", s_tready, 0);
        send('hA1, 1'b0); exp_q.push_back('hA1);
        chk("t1_w1_valid", m_tvalid, 1);
        chk("t1_w1_data", m_tdata, 'hA1);
        chk("t1_cfg_dropped", cfg_valid, 0);
        send('hA2, 1'b0); exp_q.push_back('hA2);
        chk("t1_w2_data", m_tdata, 'hA2);
        send('hA3, 1'b0); exp_q.push_back('hA3);
        chk("t1_w3_data", m_tdata, 'hA3);
        send('hA4, 1'b1); exp_q.push_back('hA4);
        chk("t1_w4_data", m_tdata, 'hA4);
        chk("t1_back_hdr_ready", s_tready, 1);
        chk("t1_busy_draining", busy, 1);
        tick();
        chk("t1_idle", busy, 0);
        chk("t1_tlast_err", tl_err, 0);

        // ---- T2: config held off for 10 cycles ----
        cfg_ready = 1'b0;
        send(16'h0403, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("t2_hold_s_tready", s_tready, 0);
            chk("t2_hold_m_tvalid", m_tvalid, 0);
            tick();
        end
        chk("t2_cfg_still_valid", cfg_valid, 1);
        cfg_ready = 1'b1;
        tick();
        chk("t2_pay_ready", s_tready, 1);
        chk("t2_no_early_data", m_tvalid, 0);
        send('hB1, 1'b0); exp_q.push_back('hB1);
        chk("t2_w1_valid", m_tvalid, 1);
        chk("t2_w1_data", m_tdata, 'hB1);
        send('hB2, 1'b0); exp_q.push_back('hB2);
        send('hB3, 1'b0); exp_q.push_back('hB3);
        send('hB4, 1'b1); exp_q.push_back('hB4);

        // ---- T3: count=0 header dropped, then a good (1,1) packet ----
        send(16'h0200, 1'b0);
        chk("t3_rej1", rej_cnt, 1);
        chk("t3_no_cfg", cfg_valid, 0);
        chk("t3_drop_ready", s_tready, 1);
        send('hC1, 1'b0);
        chk("t3_c1_no_out", m_tvalid, 0);
        send('hC2, 1'b1);
        chk("t3_c2_no_out", m_tvalid, 0);
        send(16'h0101, 1'b0);
        chk("t3_cfg_valid", cfg_valid, 1);
        chk("t3_cfg_count", cfg_count, 1);
        chk("t3_cfg_size", cfg_size, 1);
        send('hD1, 1'b1); exp_q.push_back('hD1);
        chk("t3_d1_data", m_tdata, 'hD1);
        chk("t3_tlast_err", tl_err, 0);

        // ---- T4: size=0 header, next word is a header ----
        send(16'h0007, 1'b1);
        chk("t4_rej2", rej_cnt, 2);
        chk("t4_no_cfg", cfg_valid, 0);
        chk("t4_hdr_ready", s_tready, 1);
        send(16'h0101, 1'b0);
        chk("t4_cfg_valid", cfg_valid, 1);
        send('hE1, 1'b1); exp_q.push_back('hE1);

        // ---- T5: size=5 with output backpressure ----
        send(16'h0502, 1'b0);
        chk("t5_cfg_count", cfg_count, 2);
        chk("t5_cfg_size", cfg_size, 5);
        m_tready = 1'b0;
        send('hF1, 1'b0); exp_q.push_back('hF1);
        send('hF2, 1'b0); exp_q.push_back('hF2);
        chk("t5_full_ready", s_tready, 0);
        tick();
        chk("t5_stall_ready", s_tready, 0);
        chk("t5_stall_valid", m_tvalid, 1);
        chk("t5_stall_data", m_tdata, 'hF1);
        m_tready = 1'b1;
        send('hF3, 1'b0); exp_q.push_back('hF3);
        send('hF4, 1'b0); exp_q.push_back('hF4);
        send('hF5, 1'b1); exp_q.push_back('hF5);
        chk("t5_tlast_err", tl_err, 0);

        // ---- T6: early tlast on word 2 ----
        send(16'h0403, 1'b0);
        send('h61, 1'b0); exp_q.push_back('h61);
        send('h62, 1'b1); exp_q.push_back('h62);
        chk("t6_tlast_err_set", tl_err, 1);
        send('h63, 1'b0); exp_q.push_back('h63);
        send('h64, 1'b1); exp_q.push_back('h64);
        tick();
        chk("t6_tlast_err_sticky", tl_err, 1);
        chk("t6_rej_unchanged", rej_cnt, 2);

        // ---- T7: reset mid-payload ----
        send(16'h0403, 1'b0);
        send('h71, 1'b0); exp_q.push_back('h71);
        send('h72, 1'b0); exp_q.push_back('h72);
        chk("t7_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        chk("t7_s_tready", s_tready, 0);
        chk("t7_cfg_valid", cfg_valid, 0);
        chk("t7_cfg_count", cfg_count, 0);
        chk("t7_cfg_size", cfg_size, 0);
        chk("t7_m_tvalid", m_tvalid, 0);
        chk("t7_m_tdata", m_tdata, 0);
        chk("t7_rej", rej_cnt, 0);
        chk("t7_tlast_err", tl_err, 0);
        chk("t7_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("t7_post_ready", s_tready, 1);
        tick();
        tick();

        // ---- scoreboard ----
        chk("sb_count", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk("sb_word", got_q.pop_front(), exp_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muu_repeat_header_splitter.md
# muu_repeat_header_splitter

Upstream command stage for the data repeater. It accepts a single AXI-Stream carrying a header word followed by payload words, converts each header into a count/size configuration handshake, and forwards exactly `size` payload words on a data stream. Invalid headers are rejected with their payload discarded, so the repeater never sees a zero count or zero size. It sits between the host-facing stream and the repeater's config and data inputs.

## Interface
- `DATA_WIDTH`, 512, width of header and payload words (≥16).
- `clk` in 1, clock.
- `rst` in 1, reset; synchronous, active-high.
- `s_axis_tdata` in DATA_WIDTH, header or payload word.
- `s_axis_tvalid` in 1, input valid.
- `s_axis_tready` out 1, input ready.
- `s_axis_tlast` in 1, marks the last payload word; checked only, never used for framing.
- `m_config_count` out 8, repetition count from the header.
- `m_config_size` out 8, payload word count from the header.
- `m_config_valid` out 1, config valid.
- `m_config_ready` in 1, config ready.
- `m_axis_tdata` out DATA_WIDTH, payload word.
- `m_axis_tvalid` out 1, payload valid.
- `m_axis_tready` in 1, payload ready.
- `hdr_reject_cnt` out 16, count of rejected headers; saturates at 0xFFFF.
- `tlast_err` out 1, sticky; set on any tlast mismatch.
- `busy` out 1, high in any state other than HDR, or while the skid buffer holds data.

## Operation
- Header fields: count = tdata[7:0], size = tdata[15:8]; remaining bits ignored.
- States:
  - HDR: s_axis_tready=1; wait for a header.
  - CFG: present the config; s_axis_tready=0.
  - PAY: forward payload words.
  - DROP: discard payload words.
- HDR transitions on header accept:
  - count≠0 and size≠0: latch count/size, load payload counter with size, go to CFG.
  - count=0 and size≠0: increment hdr_reject_cnt, load counter with size, go to DROP.
  - size=0: increment hdr_reject_cnt, stay in HDR. No payload follows.
- CFG: m_config_valid=1 with latched fields. On the m_config_valid & m_config_ready handshake, go to PAY. m_config_valid drops the next cycle.
- PAY:
  - s_axis_tready = skid buffer not full.
  - Each accepted word is written into the output skid buffer (2 entries) and the counter decrements.
  - The word that brings the counter to 0 returns the FSM to HDR.
- DROP: s_axis_tready=1. Words are consumed and counted down, with no output. On reaching 0, go to HDR.
- tlast check (PAY and DROP): tlast_err is set if tlast=1 on a non-final word, or tlast=0 on the final word. Framing is unaffected. tlast on a header word is ignored.
- Payload forwarding never starts before the config handshake, because the repeater only accepts data after it has taken its config.
- Counter is 8-bit. Size 255 is legal; counter never wraps below 0.

## Timing
- Reset values: s_axis_tready=0 in the reset cycle and 1 from the first cycle after; m_config_valid=0, m_config_count=0, m_config_size=0, m_axis_tvalid=0, m_axis_tdata=0, hdr_reject_cnt=0, tlast_err=0, busy=0; FSM in HDR; skid buffer empty.
- Header accepted in cycle N: m_config_valid=1 in N+1.
- Config handshake in cycle M: PAY in M+1, and the first payload word can be accepted in M+1.
- Payload word accepted in cycle K appears on m_axis in K+1 at the earliest.
- Throughput is 1 word/cycle with m_axis_tready held high.
- The skid buffer holds 2 entries and is full when 2 words are pending. m_axis_tready low for ≥2 cycles stalls input without loss or duplication. m_axis_tdata is stable while tvalid=1 and tready=0.
- The next header may be accepted in the cycle after the last payload word is accepted, while buffered payload is still draining. The config for that header may be handshaken before the drain completes.
- hdr_reject_cnt and tlast_err update the cycle after the triggering accept.
- A reset asserted mid-packet clears the FSM, counters and skid buffer in the same edge. Partially forwarded payload is lost.

## Test plan
- Header count=3, size=4, then 4 payload words (tlast on the 4th), m_axis_tready=1 → config (3,4) handshake; words appear on m_axis in order, one per cycle starting the cycle after each accept; tlast_err=0; back to HDR.
- Same packet with m_config_ready held low 10 cycles → s_axis_tready=0 throughout; no m_axis_tvalid until 1 cycle after the first payload accept following the handshake.
- Header count=0, size=2, then 2 words, then a valid header (1,1) and 1 word → hdr_reject_cnt=1; no output for the dropped words; config (1,1) follows and 1 word is forwarded.
- Header size=0 → hdr_reject_cnt increments; next word is parsed as a header.
- size=5 payload with m_axis_tready toggling 1,0,0,1 → all 5 words out, none lost or duplicated; s_axis_tready drops while the buffer is full.
- tlast asserted on word 2 of a size=4 payload → tlast_err=1 and stays set; all 4 words are still forwarded. Reset asserted mid-payload → all outputs at their reset values on the next cycle.
